// File: rtl/init_bram_seq_pkg.sv
// Shared encodings for the initialising block RAM.
// Covers the fill-sequencer states and the fill-mode codes.
package init_bram_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_STREAM = 2'd2;

endpackage

// File: rtl/init_bram_seq_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read-first read port.
// Storage is never reset; only the read-data register clears on reset.
module sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking update makes a same-address read return the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/init_bram_seq.sv
// Block RAM with an initialisation sequencer: ramp, zero or stream fill of
// words 0..INIT_LEN-1, then plain user reads/writes.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start or armed auto-start
//   FILL    | writing fill words, user port blocked
//   DONE    | last fill complete, user port live
module init_bram_seq
  import init_bram_seq_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int INIT_LEN  = 16,
  parameter int AUTO_INIT = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] base_i,
  input  logic [DW-1:0] step_i,
  input  logic          ld_valid_i,
  input  logic [DW-1:0] ld_data_i,
  output logic          ld_ready_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          busy_o,
  output logic          init_done_o,
  output logic [AW:0]   init_count_o
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(INIT_LEN - 1);

  fill_state_e   state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] step_q, step_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          arm_q, arm_d;
  logic          rd_valid_q;

  logic          fill_we;
  logic [DW-1:0] fill_wdata;
  logic          user_ok;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RAMP;
      step_q     <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      arm_q      <= (AUTO_INIT != 0);
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      arm_q      <= arm_d;
      rd_valid_q <= ram_re;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    step_d     = step_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    arm_d      = arm_q;
    fill_we    = 1'b0;
    fill_wdata = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Auto-start only fires from IDLE; DONE waits for an explicit start.
        if (start_i || (state_q == ST_IDLE && arm_q)) begin
          state_d = ST_FILL;
          mode_d  = mode_i;
          step_d  = step_i;
          acc_d   = base_i;
          addr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          arm_d   = 1'b0;
        end
      end
      ST_FILL: begin
        fill_we = (mode_q == MODE_STREAM) ? ld_valid_i : 1'b1;
        if (mode_q == MODE_RAMP)        fill_wdata = acc_q;
        else if (mode_q == MODE_STREAM) fill_wdata = ld_data_i;
        if (fill_we) begin
          addr_d = addr_q + AW'(1);
          acc_d  = acc_q + step_q;
          cnt_d  = cnt_q + (AW+1)'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign user_ok   = (state_q != ST_FILL);
  assign ram_we    = fill_we | (wr_en_i & user_ok);
  assign ram_waddr = user_ok ? wr_addr_i : addr_q;
  assign ram_wdata = user_ok ? wr_data_i : fill_wdata;
  assign ram_re    = rd_en_i & user_ok;

  sdp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_data_o)
  );

  assign ld_ready_o   = (state_q == ST_FILL) && (mode_q == MODE_STREAM);
  assign busy_o       = (state_q == ST_FILL);
  assign init_done_o  = done_q;
  assign init_count_o = cnt_q;
  assign rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_init_bram_seq.sv
// Directed bench for init_bram_seq: fill modes, blocking during fill,
// reset mid-fill and read-first collision, checked against hand-computed values.
module tb_init_bram_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] base, step;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        init_done;
  logic [8:0]  init_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  init_bram_seq #(.DW(32), .AW(8), .INIT_LEN(16), .AUTO_INIT(1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .base_i(base), .step_i(step), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .busy_o(busy), .init_done_o(init_done), .init_count_o(init_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, k, i;
    reset = 1'b1; start = 1'b0; mode = 2'd0; base = 32'd5; step = 32'd10;
    ld_valid = 1'b0; ld_data = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", init_done, 0);
    chk("rst_cnt", init_count, 0);
    chk("rst_ldrdy", ld_ready, 0);
    chk("rst_rdvld", rd_valid, 0);
    chk("rst_rddata", rd_data, 0);

    // 1: auto-start ramp 5,15,...,155
    reset = 1'b0;
    @(negedge clk);
    count_busy(n);
    chk("t1_busy_clks", n, 16);
    chk("t1_done", init_done, 1);
    chk("t1_cnt", init_count, 16);
    for (int a = 0; a < 16; a++) do_read("t1_rd", 8'(a), 32'(5 + 10 * a));
    @(negedge clk);
    chk("t1_vld_pulse", rd_valid, 0);
    chk("t1_hold", rd_data, 155);

    // 2: ramp wraps modulo 2**32
    base = 32'hFFFF_FFF0; step = 32'd8;
    pulse_start();
    count_busy(n);
    chk("t2_busy_clks", n, 16);
    do_read("t2_w0", 8'd0, 32'hFFFF_FFF0);
    do_read("t2_w2", 8'd2, 32'h0);
    do_read("t2_w3", 8'd3, 32'h8);
    do_read("t2_w15", 8'd15, 32'h68);

    // 3: stream with valid on alternate clocks
    mode = 2'd2;
    pulse_start();
    k = 0; i = 0;
    while (busy === 1'b1 && i < 200) begin
      if (i % 2 == 1) begin
        ld_valid = 1'b1; ld_data = 32'(100 + k);
        if (ld_ready === 1'b1) k++;
      end else ld_valid = 1'b0;
      @(negedge clk);
      i++;
    end
    ld_valid = 1'b0;
    chk("t3_busy_clks", i, 32);
    chk("t3_ldrdy_after", ld_ready, 0);
    chk("t3_done", init_done, 1);
    chk("t3_cnt", init_count, 16);
    do_read("t3_m0", 8'd0, 32'd100);
    do_read("t3_m7", 8'd7, 32'd107);
    do_read("t3_m15", 8'd15, 32'd115);

    do_write(8'd16, 32'h5555);

    // 4: start/wr/rd during FILL are ignored
    mode = 2'd0; base = 32'h20; step = 32'd1;
    pulse_start();
    i = 0;
    while (busy === 1'b1 && i < 200) begin
      chk("t4_cnt", init_count, i);
      chk("t4_no_rdvld", rd_valid, 0);
      start = (i < 3); wr_en = (i < 3); rd_en = (i < 3);
      wr_addr = 8'd16; wr_data = 32'hDEAD; rd_addr = 8'd16;
      @(negedge clk);
      i++;
    end
    start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("t4_busy_clks", i, 16);
    chk("t4_no_rdvld_end", rd_valid, 0);
    chk("t4_done", init_done, 1);
    do_read("t4_m16", 8'd16, 32'h5555);
    do_read("t4_m3", 8'd3, 32'h23);

    // 6: read-first collision, then refill clears init_done
    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 8'd3; rd_addr = 8'd3; wr_data = 32'hAA;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t6_coll_vld", rd_valid, 1);
    chk("t6_coll_old", rd_data, 32'h23);
    do_read("t6_new", 8'd3, 32'hAA);
    pulse_start();
    n = 0; i = 0;
    while (busy === 1'b1 && i < 200) begin
      if (init_done === 1'b0) n++;
      @(negedge clk);
      i++;
    end
    chk("t6_done_low_clks", n, 16);
    chk("t6_done", init_done, 1);
    do_read("t6_refill", 8'd3, 32'h23);

    // 5: reset mid-fill, auto zero refill
    pulse_start();
    i = 0;
    while (init_count !== 9'd7 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("t5_at7", init_count, 7);
    reset = 1'b1; mode = 2'd1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", init_done, 0);
    chk("t5_cnt", init_count, 0);
    chk("t5_ldrdy", ld_ready, 0);
    chk("t5_rdvld", rd_valid, 0);
    chk("t5_rddata", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    count_busy(n);
    chk("t5_busy_clks", n, 16);
    chk("t5_done_after", init_done, 1);
    do_read("t5_m3", 8'd3, 32'h0);
    do_read("t5_m16", 8'd16, 32'h5555);
    do_read("t5_m15", 8'd15, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
